// File: rtl/issue_queue_param_if.sv
// Decoder/dispatch-facing bundle of the issue queue; master is the decode/dispatch side, slave the queue.
interface issue_queue_param_if #(
    parameter int DEPTH = 32,
    parameter int W     = 106
);
    localparam int AW = $clog2(DEPTH);

    logic          flush;
    logic [1:0]    in_valid;
    logic [W-1:0]  in_data0;
    logic [W-1:0]  in_data1;
    logic          in_ready;
    logic [1:0]    issue_cnt;
    logic [W-1:0]  head0_data;
    logic          head0_valid;
    logic [W-1:0]  head1_data;
    logic          head1_valid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;

    modport master (
        output flush, in_valid, in_data0, in_data1, issue_cnt,
        input  in_ready, head0_data, head0_valid, head1_data, head1_valid, count, empty, full
    );

    modport slave (
        input  flush, in_valid, in_data0, in_data1, issue_cnt,
        output in_ready, head0_data, head0_valid, head1_data, head1_valid, count, empty, full
    );
endinterface

// File: rtl/issue_queue_param.sv
// Dual-lane in-order issue queue: pushed data visible on heads the cycle after the edge; in_ready needs 2 free slots, from registered state only.
// Optional ISSUE_QUEUE_KEEP_HEAD_ON_FLUSH_EN keeps an unissued head entry across a flush.
module issue_queue_param #(
    parameter int DEPTH = 32,
    parameter int W     = 106
) (
    input  logic                clk,
    input  logic                rst_,
    issue_queue_param_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP   = (AW+1)'(DEPTH);
    localparam logic [AW:0] FREE2 = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0] ONE   = (AW+1)'(1);
    localparam logic [AW:0] TWO   = (AW+1)'(2);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wp, rp, wp_next, rp_next, cnt;
    logic [AW-1:0] widx0, widx1, ridx0, ridx1;
    logic          h0v, h1v, rdy, push_ok;
    logic [1:0]    push_n, req, pop_n;

    // Wrap bit in the pointers separates full from empty.
    assign cnt   = wp - rp;
    assign rdy   = (cnt <= FREE2);
    assign h0v   = (cnt != '0);
    assign h1v   = (cnt >= TWO);

    assign ridx0 = rp[AW-1:0];
    assign ridx1 = ridx0 + AW'(1);
    assign widx0 = wp[AW-1:0];
    assign widx1 = widx0 + AW'(1);

    assign q.count       = cnt;
    assign q.empty       = (cnt == '0);
    assign q.full        = (cnt == CAP);
    assign q.in_ready    = rdy;
    assign q.head0_valid = h0v;
    assign q.head1_valid = h1v;
    assign q.head0_data  = h0v ? mem[ridx0] : '0;
    assign q.head1_data  = h1v ? mem[ridx1] : '0;

    // Lane 1 alone is treated as no request.
    assign push_ok = rdy && q.in_valid[0] && !q.flush;

    always_comb begin
        push_n = 2'd0;
        if (push_ok) begin
            push_n = q.in_valid[1] ? 2'd2 : 2'd1;
        end

        req = (q.issue_cnt == 2'd0) ? 2'd0 :
              (q.issue_cnt == 2'd1) ? 2'd1 : 2'd2;
        if (!h0v) begin
            pop_n = 2'd0;
        end else if (!h1v && req == 2'd2) begin
            pop_n = 2'd1;
        end else begin
            pop_n = req;
        end
    end

    always_comb begin
        wp_next = wp + {{(AW-1){1'b0}}, push_n};
        rp_next = rp + {{(AW-1){1'b0}}, pop_n};
        if (q.flush) begin
`ifdef ISSUE_QUEUE_KEEP_HEAD_ON_FLUSH_EN
            if (q.issue_cnt == 2'd0 && h0v) begin
                rp_next = rp;
                wp_next = rp + ONE;
            end else begin
                rp_next = '0;
                wp_next = '0;
            end
`else
            rp_next = '0;
            wp_next = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wp <= wp_next;
            rp <= rp_next;
            if (push_ok) begin
                mem[widx0] <= q.in_data0;
                if (q.in_valid[1]) begin
                    mem[widx1] <= q.in_data1;
                end
            end
        end
    end
endmodule

// File: tb/tb_issue_queue_param.sv
// Directed bench for issue_queue_param (DEPTH=8, W=8): stimulus queues expected post-edge state, a negedge monitor compares.
module tb_issue_queue_param;
    localparam int DEPTH = 8;
    localparam int W     = 8;
`ifdef ISSUE_QUEUE_KEEP_HEAD_ON_FLUSH_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    issue_queue_param_if #(.DEPTH(DEPTH), .W(W)) q();
    issue_queue_param #(.DEPTH(DEPTH), .W(W)) dut (.clk(clk), .rst_(rst_), .q(q));

    typedef struct packed {
        logic [8*12-1:0] name;
        logic [24:0]     v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    // Expected {count, h0v, h0, h1v, h1, in_ready, empty, full} for a given occupancy and head values.
    function automatic logic [24:0] mk(input int c, input logic [7:0] h0, input logic [7:0] h1);
        logic [3:0] cc;
        cc = 4'(c);
        return {cc, (c >= 1), h0, (c >= 2), h1, (c <= DEPTH - 2), (c == 0), (c == DEPTH)};
    endfunction

    always @(posedge clk) begin
        assert (!(rst_ && q.in_valid == 2'b10))
            else $error("FAIL illegal_in_valid: got 2'b10, required lane0 set when lane1 set");
    end

    logic [24:0] act;
    exp_t        cur;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            act = {q.count, q.head0_valid, q.head0_data, q.head1_valid, q.head1_data,
                   q.in_ready, q.empty, q.full};
            checks++;
            if (act === cur.v) begin
                passed++;
            end else begin
                $display("FAIL %s: cnt/h0v/h0/h1v/h1/rdy/emp/full got %0d/%b/%h/%b/%h/%b/%b/%b required %0d/%b/%h/%b/%h/%b/%b/%b",
                         cur.name,
                         act[24:21], act[20], act[19:12], act[11], act[10:3], act[2], act[1], act[0],
                         cur.v[24:21], cur.v[20], cur.v[19:12], cur.v[11], cur.v[10:3], cur.v[2], cur.v[1], cur.v[0]);
            end
        end
    end

    task automatic expect_now(input logic [8*12-1:0] nm, input logic [24:0] ev);
        exp_t t;
        t.name = nm;
        t.v    = ev;
        sb.push_back(t);
    endtask

    task automatic step(input logic fl, input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] ic, input logic [8*12-1:0] nm, input logic [24:0] ev);
        q.flush     = fl;
        q.in_valid  = iv;
        q.in_data0  = a;
        q.in_data1  = b;
        q.issue_cnt = ic;
        @(posedge clk);
        #1;
        expect_now(nm, ev);
        q.flush     = 1'b0;
        q.in_valid  = 2'b00;
        q.issue_cnt = 2'd0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        q.flush     = 1'b0;
        q.in_valid  = 2'b00;
        q.in_data0  = '0;
        q.in_data1  = '0;
        q.issue_cnt = 2'd0;
        #2;
        expect_now("reset", mk(0, 8'h00, 8'h00));
        @(negedge clk);
        rst_ = 1'b1;

        // Fill to full, then a dropped push.
        step(0, 2'b11, 8'h01, 8'h02, 2'd0, "fill1",   mk(2, 8'h01, 8'h02));
        step(0, 2'b11, 8'h03, 8'h04, 2'd0, "fill2",   mk(4, 8'h01, 8'h02));
        step(0, 2'b11, 8'h05, 8'h06, 2'd0, "fill3",   mk(6, 8'h01, 8'h02));
        step(0, 2'b11, 8'h07, 8'h08, 2'd0, "fill_full", mk(8, 8'h01, 8'h02));
        step(0, 2'b11, 8'h09, 8'h0A, 2'd0, "drop",    mk(8, 8'h01, 8'h02));

        // Pops including over-requests.
        step(0, 2'b00, 8'h00, 8'h00, 2'd1, "pop1",    mk(7, 8'h02, 8'h03));
        step(0, 2'b00, 8'h00, 8'h00, 2'd3, "pop3as2", mk(5, 8'h04, 8'h05));
        step(0, 2'b00, 8'h00, 8'h00, 2'd2, "pop2a",   mk(3, 8'h06, 8'h07));
        step(0, 2'b00, 8'h00, 8'h00, 2'd2, "pop2b",   mk(1, 8'h08, 8'h00));
        step(0, 2'b00, 8'h00, 8'h00, 2'd2, "pop_clamp", mk(0, 8'h00, 8'h00));

        // Refill to 6, then push 2 / pop 2 across the index wrap.
        step(0, 2'b11, 8'h11, 8'h12, 2'd0, "wfill1",  mk(2, 8'h11, 8'h12));
        step(0, 2'b11, 8'h13, 8'h14, 2'd0, "wfill2",  mk(4, 8'h11, 8'h12));
        step(0, 2'b11, 8'h15, 8'h16, 2'd0, "wfill3",  mk(6, 8'h11, 8'h12));
        step(0, 2'b11, 8'h17, 8'h18, 2'd2, "wrap1",   mk(6, 8'h13, 8'h14));
        step(0, 2'b11, 8'h19, 8'h1A, 2'd2, "wrap2",   mk(6, 8'h15, 8'h16));
        step(0, 2'b11, 8'h1B, 8'h1C, 2'd2, "wrap3",   mk(6, 8'h17, 8'h18));
        step(0, 2'b11, 8'h1D, 8'h1E, 2'd2, "wrap4",   mk(6, 8'h19, 8'h1A));
        step(0, 2'b00, 8'h00, 8'h00, 2'd2, "drain1",  mk(4, 8'h1B, 8'h1C));
        step(0, 2'b00, 8'h00, 8'h00, 2'd2, "drain2",  mk(2, 8'h1D, 8'h1E));
        step(0, 2'b00, 8'h00, 8'h00, 2'd2, "drain3",  mk(0, 8'h00, 8'h00));

        // Count 5 with head 11, then flushes (flush also carries a push that must be ignored).
        step(0, 2'b11, 8'h11, 8'h21, 2'd0, "fset1",   mk(2, 8'h11, 8'h21));
        step(0, 2'b11, 8'h22, 8'h23, 2'd0, "fset2",   mk(4, 8'h11, 8'h21));
        step(0, 2'b01, 8'h24, 8'hFF, 2'd0, "fset3",   mk(5, 8'h11, 8'h21));
        step(1, 2'b11, 8'hAA, 8'hBB, 2'd0, "flush_ic0",
             KEEP ? mk(1, 8'h11, 8'h00) : mk(0, 8'h00, 8'h00));
        step(0, 2'b11, 8'h31, 8'h32, 2'd0, "post_flush",
             KEEP ? mk(3, 8'h11, 8'h31) : mk(2, 8'h31, 8'h32));
        step(1, 2'b11, 8'hCC, 8'hDD, 2'd1, "flush_ic1", mk(0, 8'h00, 8'h00));
        step(1, 2'b11, 8'hEE, 8'hEF, 2'd0, "flush_empty", mk(0, 8'h00, 8'h00));

        // Simultaneous push and pop, then asynchronous reset mid-stream.
        step(0, 2'b11, 8'h41, 8'h42, 2'd0, "pp1",     mk(2, 8'h41, 8'h42));
        step(0, 2'b11, 8'h43, 8'h44, 2'd1, "pp2",     mk(3, 8'h42, 8'h43));
        #2;
        rst_ = 1'b0;
        #1;
        expect_now("mid_reset", mk(0, 8'h00, 8'h00));
        @(negedge clk);
        rst_ = 1'b1;
        step(0, 2'b01, 8'h51, 8'h52, 2'd0, "after_rst", mk(1, 8'h51, 8'h00));
        step(0, 2'b00, 8'h00, 8'h00, 2'd3, "last_pop", mk(0, 8'h00, 8'h00));

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
